// File: rtl/jtframe_ddr_dwnld_pkg.sv
// Shared definitions for the DDR-to-programming-port ROM streamer.
package jtframe_ddr_dwnld_pkg;

    // Fetch side: pulls bursts from DDR into the ping-pong buffer
    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_DATA,
        F_HOLD
    } fetch_state_t;

    // Emit side: drains the ping-pong buffer into the core, one write at a time
    typedef enum logic [1:0] {
        E_IDLE,
        E_LOAD,
        E_WR,
        E_ACK
    } emit_state_t;

    // DDR word address of image byte 0 (byte address 0x3000_0000)
    localparam logic [28:0] DEFAULT_BASE = 29'h0600_0000;

    // Only byte and halfword output ports are supported
    function automatic bit outw_ok(input int w);
        return (w == 8) || (w == 16);
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
module jtframe_dual_ram #(
    parameter int dw = 64,
    parameter int aw = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [dw-1:0] din,
    input  logic [aw-1:0] raddr,
    output logic [dw-1:0] dout
);
    logic [dw-1:0] mem [0:(1<<aw)-1];
    logic [dw-1:0] dout_q;

    // Write port and one-cycle-latency read port
    // NOTE: the storage array has no reset; every location is written before it is read,
    //       and a reset would turn the array into flops instead of block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
        dout_q <= mem[raddr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/jtframe_ddr_dwnld.sv
// Streams a ROM image from DDR3 into the core's programming port through a
// two-bank ping-pong buffer so that DDR bursts overlap the (slow) core writes.
module jtframe_ddr_dwnld
    import jtframe_ddr_dwnld_pkg::*;
#(
    parameter int          BW   = 7,
    parameter int          OUTW = 8,
    parameter logic [28:0] BASE = DEFAULT_BASE,
    parameter int          AW   = 27
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   len,
    output logic            busy,
    output logic            done,
    input  logic            ddram_busy,
    output logic [7:0]      ddram_burstcnt,
    output logic [28:0]     ddram_addr,
    output logic            ddram_rd,
    input  logic [63:0]     ddram_dout,
    input  logic            ddram_dout_ready,
    output logic            dump_we,
    output logic [AW-1:0]   dump_addr,
    output logic [OUTW-1:0] dump_data,
    input  logic            prog_rdy
);
    localparam int            PW       = 29 - BW;      // page counter width
    localparam int            NSUB     = 64 / OUTW;    // writes per 64-bit word
    localparam int            SW       = $clog2(NSUB);
    localparam logic [SW-1:0] SUB_LAST = SW'(NSUB - 1);
    localparam logic [AW-1:0] STEP     = AW'(OUTW / 8);

    generate
        if (!outw_ok(OUTW)) begin : g_bad_outw
            $error("jtframe_ddr_dwnld: OUTW must be 8 or 16");
        end
    endgenerate

    fetch_state_t    fst_q, fst_d;
    emit_state_t     est_q, est_d;
    logic [PW-1:0]   page_q, page_d;
    logic [BW-1:0]   fcnt_q, fcnt_d;
    logic [1:0]      valid_q, valid_d;
    logic            ebank_q, ebank_d;
    logic [BW-1:0]   eword_q, eword_d;
    logic [SW-1:0]   sub_q, sub_d;
    logic [63:0]     shift_q, shift_d;
    logic [AW-1:0]   dump_addr_q, dump_addr_d;
    logic [AW-1:0]   len_q, len_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            ram_we;
    logic [BW:0]     ram_waddr, ram_raddr;
    logic [63:0]     ram_dout;

    jtframe_dual_ram #(.dw(64), .aw(BW + 1)) u_buf (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .din   (ddram_dout),
        .raddr (ram_raddr),
        .dout  (ram_dout)
    );

    // Read address follows the emitter's next position so the word is ready in E_LOAD
    assign ram_raddr = {ebank_d, eword_d};

    // Start handling plus both FSMs: fetcher fills banks, emitter drains them
    // NOTE: every signal gets a default before the case logic, so no path leaves one
    //       unassigned and no latch is inferred.
    always_comb begin
        fst_d       = fst_q;
        est_d       = est_q;
        page_d      = page_q;
        fcnt_d      = fcnt_q;
        valid_d     = valid_q;
        ebank_d     = ebank_q;
        eword_d     = eword_q;
        sub_d       = sub_q;
        shift_d     = shift_q;
        dump_addr_d = dump_addr_q;
        len_d       = len_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = {page_q[0], fcnt_q};
        ddram_rd    = 1'b0;
        dump_we     = 1'b0;

        if (!busy_q) begin
            if (start) begin
                len_d       = len;
                dump_addr_d = '0;
                page_d      = '0;
                fcnt_d      = '0;
                valid_d     = '0;
                ebank_d     = 1'b0;
                eword_d     = '0;
                sub_d       = '0;
                if (len == '0) begin
                    done_d = 1'b1;           // nothing to move: finish without touching DDR
                end else begin
                    busy_d = 1'b1;
                    fst_d  = F_REQ;
                    est_d  = E_IDLE;
                end
            end
        end else begin
            case (fst_q)
                F_REQ: begin
                    ddram_rd = 1'b1;
                    if (!ddram_busy) fst_d = F_DATA;
                end
                F_DATA: begin
                    if (ddram_dout_ready) begin
                        ram_we = 1'b1;
                        fcnt_d = fcnt_q + 1'b1;
                        if (&fcnt_q) begin
                            valid_d[page_q[0]] = 1'b1;
                            page_d = page_q + 1'b1;
                            if ({page_d, {(BW + 3){1'b0}}} >= 32'(len_q)) fst_d = F_IDLE;
                            else if (!valid_q[page_d[0]])                  fst_d = F_REQ;
                            else                                           fst_d = F_HOLD;
                        end
                    end
                end
                F_HOLD: begin
                    if (!valid_q[page_q[0]]) fst_d = F_REQ;
                end
                default: ;
            endcase

            case (est_q)
                E_IDLE: begin
                    if (valid_q[ebank_q]) est_d = E_LOAD;
                end
                E_LOAD: begin
                    shift_d = ram_dout;
                    est_d   = E_WR;
                end
                E_WR: begin
                    dump_we = 1'b1;
                    est_d   = E_ACK;
                end
                E_ACK: begin
                    if (prog_rdy) begin
                        dump_addr_d = dump_addr_q + STEP;
                        shift_d     = shift_q >> OUTW;
                        sub_d       = sub_q + 1'b1;
                        if (({1'b0, dump_addr_q} + {1'b0, STEP}) >= {1'b0, len_q}) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            est_d   = E_IDLE;
                            fst_d   = F_IDLE;
                            valid_d = '0;
                        end else if (sub_q == SUB_LAST) begin
                            sub_d   = '0;
                            eword_d = eword_q + 1'b1;
                            if (&eword_q) begin
                                valid_d[ebank_q] = 1'b0;   // bank drained, hand it back
                                ebank_d          = ~ebank_q;
                                est_d            = E_IDLE;
                            end else begin
                                est_d = E_LOAD;
                            end
                        end else begin
                            est_d = E_WR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers, all cleared at once by rst
    // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fst_q       <= F_IDLE;
            est_q       <= E_IDLE;
            page_q      <= '0;
            fcnt_q      <= '0;
            valid_q     <= '0;
            ebank_q     <= 1'b0;
            eword_q     <= '0;
            sub_q       <= '0;
            shift_q     <= '0;
            dump_addr_q <= '0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fst_q       <= fst_d;
            est_q       <= est_d;
            page_q      <= page_d;
            fcnt_q      <= fcnt_d;
            valid_q     <= valid_d;
            ebank_q     <= ebank_d;
            eword_q     <= eword_d;
            sub_q       <= sub_d;
            shift_q     <= shift_d;
            dump_addr_q <= dump_addr_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign dump_addr      = dump_addr_q;
    assign dump_data      = shift_q[OUTW-1:0];
    assign ddram_burstcnt = 8'(1 << BW);
    assign ddram_addr     = BASE + {page_q, {BW{1'b0}}};

endmodule

// File: tb/tb_jtframe_ddr_dwnld.sv
// Self-checking bench: one 8-bit and one 16-bit instance share a DDR responder
// and a core model; only the selected instance is ever started.
module tb_jtframe_ddr_dwnld;
    localparam int          BW    = 7;
    localparam int          AW    = 27;
    localparam logic [28:0] BASE  = 29'h0600_0000;
    localparam int          BURST = 1 << BW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    logic            start, sel16, start8, start16;
    logic [AW-1:0]   len;
    logic            ddram_busy, ddram_dout_ready, prog_rdy;
    logic [63:0]     ddram_dout;

    logic            busy8, done8, rd8, we8, busy16, done16, rd16, we16;
    logic [7:0]      bc8, bc16, data8;
    logic [15:0]     data16;
    logic [28:0]     addr8, addr16;
    logic [AW-1:0]   daddr8, daddr16;

    logic            busy, done, ddram_rd, dump_we;
    logic [7:0]      ddram_burstcnt;
    logic [28:0]     ddram_addr;
    logic [AW-1:0]   dump_addr;
    logic [15:0]     dump_data;

    assign start8  = start & ~sel16;
    assign start16 = start & sel16;
    assign busy           = sel16 ? busy16  : busy8;
    assign done           = sel16 ? done16  : done8;
    assign ddram_rd       = sel16 ? rd16    : rd8;
    assign dump_we        = sel16 ? we16    : we8;
    assign ddram_burstcnt = sel16 ? bc16    : bc8;
    assign ddram_addr     = sel16 ? addr16  : addr8;
    assign dump_addr      = sel16 ? daddr16 : daddr8;
    assign dump_data      = sel16 ? data16  : {8'h00, data8};

    jtframe_ddr_dwnld #(.BW(BW), .OUTW(8), .BASE(BASE), .AW(AW)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .len(len), .busy(busy8), .done(done8),
        .ddram_busy(ddram_busy), .ddram_burstcnt(bc8), .ddram_addr(addr8), .ddram_rd(rd8),
        .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
        .dump_we(we8), .dump_addr(daddr8), .dump_data(data8), .prog_rdy(prog_rdy));

    jtframe_ddr_dwnld #(.BW(BW), .OUTW(16), .BASE(BASE), .AW(AW)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .len(len), .busy(busy16), .done(done16),
        .ddram_busy(ddram_busy), .ddram_burstcnt(bc16), .ddram_addr(addr16), .ddram_rd(rd16),
        .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
        .dump_we(we16), .dump_addr(daddr16), .dump_data(data16), .prog_rdy(prog_rdy));

    // ---------------- reference image ----------------
    function automatic logic [63:0] ddr_word(input logic [28:0] a);
        logic [31:0] x;
        x = {3'b000, a};
        return {x * 32'h9E37_79B1, x ^ 32'h5A5A_C3C3};
    endfunction

    function automatic logic [7:0] img_byte(input int i);
        logic [63:0] w;
        w = ddr_word(BASE + 29'(i / 8));
        return w[(i % 8) * 8 +: 8];
    endfunction

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cur_len, wr_cnt, burst_cnt, done_cnt, rd_seen, rd_busy_cycles;
    int busy_hold, rdy_hold, words_left, widx;
    bit rand_rdy, rand_busy, held, prev_we;
    logic [28:0] held_addr, cur_addr;
    logic [28:0] pend[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: sample DUT outputs at the falling edge, then drive DDR and core inputs
    task automatic tick();
        logic [15:0] e, m;
        int a;
        @(negedge clk);
        if (rst) begin
            pend.delete();
            words_left = 0;
            ddram_dout_ready = 1'b0;
            held = 1'b0;
            prev_we = 1'b0;
            return;
        end
        if (dump_we) begin
            a = wr_cnt * (sel16 ? 2 : 1);
            check("we_one_cycle", 64'(prev_we), 64'd0);
            check("wr_addr", 64'(dump_addr), 64'(a));
            e = sel16 ? {img_byte(a + 1), img_byte(a)} : {8'h00, img_byte(a)};
            m = (sel16 && (a + 1 < cur_len)) ? 16'hFFFF : 16'h00FF;
            check("wr_data", 64'(dump_data & m), 64'(e & m));
            wr_cnt++;
        end
        prev_we = dump_we;
        if (done)     done_cnt++;
        if (ddram_rd) rd_seen++;

        ddram_dout_ready = 1'b0;
        if (words_left == 0 && pend.size() > 0) begin
            cur_addr   = pend.pop_front();
            words_left = BURST;
            widx       = 0;
        end
        if (words_left > 0 && !(rand_busy && $urandom_range(3) == 0)) begin
            ddram_dout       = ddr_word(cur_addr + 29'(widx));
            ddram_dout_ready = 1'b1;
            widx++;
            words_left--;
        end

        ddram_busy = (busy_hold > 0) || (rand_busy && $urandom_range(3) == 0);
        if (ddram_rd) begin
            if (held) check("rd_addr_stable", 64'(ddram_addr), 64'(held_addr));
            if (!ddram_busy) begin
                check("burst_addr", 64'(ddram_addr), 64'(BASE + 29'(burst_cnt * BURST)));
                check("burstcnt", 64'(ddram_burstcnt), 64'(BURST));
                pend.push_back(ddram_addr);
                burst_cnt++;
                held = 1'b0;
            end else begin
                if (busy_hold > 0) busy_hold--;
                rd_busy_cycles++;
                held      = 1'b1;
                held_addr = ddram_addr;
            end
        end else begin
            held = 1'b0;
        end

        if (rdy_hold > 0) begin
            prog_rdy = 1'b0;
            rdy_hold--;
        end else begin
            prog_rdy = rand_rdy ? ($urandom_range(2) != 0) : 1'b1;
        end
    endtask

    task automatic kick(input int l, input bit w16);
        sel16 = w16;
        cur_len = l;
        wr_cnt = 0; burst_cnt = 0; done_cnt = 0; rd_seen = 0; rd_busy_cycles = 0;
        held = 1'b0;
        len = AW'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (l != 0) check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && done_cnt == 0; c++) tick();
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        repeat (10) tick();
    endtask

    task automatic wait_writes(input int n);
        for (int c = 0; c < 5000 && wr_cnt < n; c++) tick();
        check("reached_writes", 64'(wr_cnt >= n), 64'd1);
    endtask

    task automatic end_checks(input int exp_wr, input int exp_b);
        check("writes", 64'(wr_cnt), 64'(exp_wr));
        check("bursts", 64'(burst_cnt), 64'(exp_b));
        check("done_once", 64'(done_cnt), 64'd1);
        check("busy_clear", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'({busy8, busy16}), 64'd0);
        check({tag, "_done"}, 64'({done8, done16}), 64'd0);
        check({tag, "_rd"},   64'({rd8, rd16}), 64'd0);
        check({tag, "_we"},   64'({we8, we16}), 64'd0);
        check({tag, "_addr"}, 64'({daddr8, daddr16}), 64'd0);
        check({tag, "_data"}, 64'({data8, data16}), 64'd0);
    endtask

    typedef struct {
        int len;
        bit w16;
        bit rrdy;
        bit rbusy;
        int exp_wr;
        int exp_bursts;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int l, r0, w0;
        bit w;
        start = 1'b0; sel16 = 1'b0; len = '0;
        ddram_busy = 1'b0; ddram_dout_ready = 1'b0; ddram_dout = '0; prog_rdy = 1'b1;
        busy_hold = 0; rdy_hold = 0; rand_rdy = 1'b0; rand_busy = 1'b0;
        cur_len = 0; wr_cnt = 0; burst_cnt = 0; done_cnt = 0; rd_seen = 0; rd_busy_cycles = 0;
        words_left = 0; widx = 0; held = 1'b0; prev_we = 1'b0; held_addr = '0; cur_addr = '0;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // {len, 16-bit, random prog_rdy, random DDR stalls, writes, bursts}
        vecs.push_back('{2048, 1'b0, 1'b0, 1'b0, 2048, 2});
        vecs.push_back('{1027, 1'b1, 1'b0, 1'b0,  514, 2});
        vecs.push_back('{   1, 1'b0, 1'b0, 1'b0,    1, 1});
        vecs.push_back('{   1, 1'b1, 1'b0, 1'b0,    1, 1});
        vecs.push_back('{1024, 1'b0, 1'b1, 1'b0, 1024, 1});
        vecs.push_back('{1025, 1'b0, 1'b1, 1'b1, 1025, 2});
        vecs.push_back('{3000, 1'b1, 1'b1, 1'b1, 1500, 3});
        for (int k = 0; k < 3; k++) begin
            l = int'($urandom_range(1500, 1));
            w = 1'($urandom_range(1));
            vecs.push_back('{l, w, 1'b1, 1'b1, w ? (l + 1) / 2 : l, (l + 1023) / 1024});
        end

        foreach (vecs[i]) begin
            rand_rdy  = vecs[i].rrdy;
            rand_busy = vecs[i].rbusy;
            kick(vecs[i].len, vecs[i].w16);
            wait_done(20000);
            end_checks(vecs[i].exp_wr, vecs[i].exp_bursts);
        end
        rand_rdy = 1'b0;
        rand_busy = 1'b0;

        // Core stalls mid-bank: fetcher must park after filling both banks
        kick(4096, 1'b0);
        wait_writes(300);
        rdy_hold = 500;
        repeat (100) tick();
        r0 = rd_seen;
        w0 = wr_cnt;
        repeat (380) tick();
        check("hold_no_request", 64'(rd_seen), 64'(r0));
        check("hold_no_write", 64'(wr_cnt), 64'(w0));
        check("hold_two_bursts", 64'(burst_cnt), 64'd2);
        wait_done(20000);
        end_checks(4096, 4);

        // DDR waitrequest for 20 cycles on the first request
        busy_hold = 20;
        kick(512, 1'b0);
        wait_done(5000);
        end_checks(512, 1);
        check("rd_held_cycles", 64'(rd_busy_cycles), 64'd20);

        // Zero length: done on the next cycle, DDR untouched
        kick(0, 1'b0);
        check("len0_done", 64'(done), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        tick();
        check("len0_done_pulse", 64'(done), 64'd0);
        repeat (20) tick();
        check("len0_no_rd", 64'(rd_seen), 64'd0);
        check("len0_no_write", 64'(wr_cnt), 64'd0);

        // Second start while busy is ignored
        kick(600, 1'b0);
        wait_writes(50);
        len = AW'(16);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(5000);
        end_checks(600, 1);

        // Reset mid-transfer, then restart from page 0
        kick(2048, 1'b0);
        wait_writes(300);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) tick();
        rst = 1'b0;
        tick();
        kick(300, 1'b0);
        wait_done(5000);
        end_checks(300, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
